// File: rtl/cp0_regs.sv
// MIPS coprocessor-0 register block: BadVAddr, Count/Compare timer, Status, Cause, EPC, PRId.
// Serves mfc0/mtc0, records exception entry and eret, and raises the interrupt request.
module cp0_regs #(
  parameter int          COUNT_DIV    = 2,
  parameter int          NUM_HW_INT   = 5,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0000,
  parameter logic [31:0] PRID         = 32'h0001_8000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [4:0]            i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic [4:0]            i_raddr,
  output logic [31:0]           o_rdata,
  input  logic                  i_exc_valid,
  input  logic [4:0]            i_exc_code,
  input  logic [31:0]           i_exc_pc,
  input  logic                  i_exc_bd,
  input  logic [31:0]           i_exc_badvaddr,
  input  logic                  i_eret,
  input  logic [NUM_HW_INT-1:0] i_hw_int,
  output logic [31:0]           o_epc_out,
  output logic                  o_exl_out,
  output logic                  o_int_req
);

  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;
  localparam int          PW          = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  logic [31:0]           r_badvaddr;
  logic [31:0]           r_count;
  logic [PW-1:0]         r_presc;
  logic [31:0]           r_compare;
  logic [31:0]           r_status;
  logic                  r_bd;
  logic                  r_ip_timer;
  logic [NUM_HW_INT-1:0] r_ip_hw;
  logic [1:0]            r_ip_sw;
  logic [4:0]            r_exccode;
  logic [31:0]           r_epc;

  logic        w_wr;
  logic        w_tick;
  logic        w_count_wr;
  logic        w_compare_wr;
  logic [31:0] w_count_inc;
  logic [31:0] w_cause;

  // An exception in the same cycle swallows any mtc0.
  assign w_wr         = i_we & ~i_exc_valid;
  assign w_count_wr   = w_wr && (i_waddr == A_COUNT);
  assign w_compare_wr = w_wr && (i_waddr == A_COMPARE);
  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_count_inc  = r_count + 32'd1;

  always_comb begin
    w_cause                     = 32'd0;
    w_cause[31]                 = r_bd;
    w_cause[15]                 = r_ip_timer;
    w_cause[10 +: NUM_HW_INT]   = r_ip_hw;
    w_cause[9:8]                = r_ip_sw;
    w_cause[6:2]                = r_exccode;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count    <= 32'd0;
      r_presc    <= '0;
      r_compare  <= 32'hFFFF_FFFF;
      r_ip_timer <= 1'b0;
    end else begin
      if (w_count_wr) begin
        r_count <= i_wdata;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      // Clearing via a Compare write takes precedence over a coincident match.
      if (w_compare_wr) begin
        r_compare  <= i_wdata;
        r_ip_timer <= 1'b0;
      end else if (w_tick && !w_count_wr && (w_count_inc == r_compare)) begin
        r_ip_timer <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status   <= RESET_STATUS & STATUS_MASK;
      r_bd       <= 1'b0;
      r_ip_hw    <= '0;
      r_ip_sw    <= 2'b00;
      r_exccode  <= 5'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_ip_hw <= i_hw_int;
      if (i_exc_valid) begin
        if (!r_status[1]) begin
          r_epc <= i_exc_bd ? (i_exc_pc - 32'd4) : i_exc_pc;
          r_bd  <= i_exc_bd;
        end
        r_exccode   <= i_exc_code;
        r_status[1] <= 1'b1;
        if ((i_exc_code == 5'd4) || (i_exc_code == 5'd5))
          r_badvaddr <= i_exc_badvaddr;
      end else begin
        if (w_wr && (i_waddr == A_STATUS)) r_status <= i_wdata & STATUS_MASK;
        if (w_wr && (i_waddr == A_CAUSE))  r_ip_sw  <= i_wdata[9:8];
        if (w_wr && (i_waddr == A_EPC))    r_epc    <= i_wdata;
        if (i_eret)                        r_status[1] <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_raddr)
      A_BADVADDR: o_rdata = r_badvaddr;
      A_COUNT:    o_rdata = r_count;
      A_COMPARE:  o_rdata = r_compare;
      A_STATUS:   o_rdata = r_status;
      A_CAUSE:    o_rdata = w_cause;
      A_EPC:      o_rdata = r_epc;
      A_PRID:     o_rdata = PRID;
      default:    o_rdata = 32'd0;
    endcase
  end

  assign o_epc_out = r_epc;
  assign o_exl_out = r_status[1];
  assign o_int_req = r_status[0] & ~r_status[1] & (|(w_cause[15:8] & r_status[15:8]));

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs with default parameters (COUNT_DIV=2, NUM_HW_INT=5).
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_cp0_regs;
  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [4:0]  hw_int;
  logic [31:0] epc_out;
  logic        exl_out;
  logic        int_req;

  int checks = 0;
  int errors = 0;

  cp0_regs dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
    .i_exc_pc(exc_pc), .i_exc_bd(exc_bd), .i_exc_badvaddr(exc_badvaddr), .i_eret(eret),
    .i_hw_int(hw_int), .o_epc_out(epc_out), .o_exl_out(exl_out), .o_int_req(int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #2;
    rd(5'd12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", v, 32'h0); end
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp %h", v, 32'h0); end
    rd(5'd14, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp %h", v, 32'h0); end
    rd(5'd11, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h exp %h", v, 32'hFFFF_FFFF); end
    checks++; if (exl_out !== 1'b0 || int_req !== 1'b0 || epc_out !== 32'h0) begin errors++; $display("FAIL reset_outs got exl=%b int=%b epc=%h exp 0 0 0", exl_out, int_req, epc_out); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    rd(5'd9, v); checks++; if (v !== 32'd1) begin errors++; $display("FAIL count_after2 got %h exp %h", v, 32'd1); end
    repeat (8) tick();
    rd(5'd9, v); checks++; if (v !== 32'd5) begin errors++; $display("FAIL count_after10 got %h exp %h", v, 32'd5); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    mtc0(5'd9, 32'h0000_000A);
    mtc0(5'd11, 32'h0000_000C);
    mtc0(5'd12, 32'h0000_8001);
    tick();
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL timer_early got %h exp %h", v, 32'h0); end
    tick();
    rd(5'd13, v); checks++; if (v !== 32'h0000_8000) begin errors++; $display("FAIL timer_ip7 got %h exp %h", v, 32'h0000_8000); end
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL timer_int got %b exp 1", int_req); end
    mtc0(5'd11, 32'h0000_0100);
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL timer_clear got %h exp %h", v, 32'h0); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL timer_int_clear got %b exp 0", int_req); end
    // Count steps C->D on the same edge that Compare is written to D.
    mtc0(5'd11, 32'h0000_000D);
    rd(5'd9, v); checks++; if (v !== 32'h0000_000D) begin errors++; $display("FAIL timer_count_d got %h exp %h", v, 32'h0000_000D); end
    rd(5'd13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL timer_clear_wins got %h exp %h", v, 32'h0); end
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_exception();
    logic [31:0] v;
    exc_valid = 1'b1; exc_pc = 32'h0040_0010; exc_bd = 1'b1; exc_code = 5'd4; exc_badvaddr = 32'h1234_5677;
    tick();
    exc_valid = 1'b0;
    rd(5'd14, v); checks++; if (v !== 32'h0040_000C || epc_out !== 32'h0040_000C) begin errors++; $display("FAIL exc_epc got %h/%h exp %h", v, epc_out, 32'h0040_000C); end
    rd(5'd13, v); checks++; if (v !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause got %h exp %h", v, 32'h8000_0010); end
    rd(5'd8, v);  checks++; if (v !== 32'h1234_5677) begin errors++; $display("FAIL exc_badvaddr got %h exp %h", v, 32'h1234_5677); end
    rd(5'd12, v); checks++; if (v !== 32'h2 || exl_out !== 1'b1) begin errors++; $display("FAIL exc_exl got %h/%b exp %h/1", v, exl_out, 32'h2); end
    exc_valid = 1'b1; exc_pc = 32'h0040_0100; exc_bd = 1'b0; exc_code = 5'd8; exc_badvaddr = 32'hFFFF_FFFF;
    we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    exc_valid = 1'b0; we = 1'b0;
    rd(5'd14, v); checks++; if (v !== 32'h0040_000C) begin errors++; $display("FAIL nested_epc got %h exp %h", v, 32'h0040_000C); end
    rd(5'd13, v); checks++; if (v !== 32'h8000_0020) begin errors++; $display("FAIL nested_cause got %h exp %h", v, 32'h8000_0020); end
    rd(5'd8, v);  checks++; if (v !== 32'h1234_5677) begin errors++; $display("FAIL nested_badvaddr got %h exp %h", v, 32'h1234_5677); end
  endtask

  task automatic test_eret();
    logic [31:0] v;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (exl_out !== 1'b0) begin errors++; $display("FAIL eret_exl got %b exp 0", exl_out); end
    rd(5'd13, v); checks++; if (v !== 32'h8000_0020) begin errors++; $display("FAIL eret_cause got %h exp %h", v, 32'h8000_0020); end
    eret = 1'b1; exc_valid = 1'b1; exc_pc = 32'h0040_0200; exc_bd = 1'b0; exc_code = 5'd12;
    tick();
    eret = 1'b0; exc_valid = 1'b0;
    checks++; if (exl_out !== 1'b1) begin errors++; $display("FAIL eret_exc_exl got %b exp 1", exl_out); end
    checks++; if (epc_out !== 32'h0040_0200) begin errors++; $display("FAIL eret_exc_epc got %h exp %h", epc_out, 32'h0040_0200); end
    rd(5'd13, v); checks++; if (v !== 32'h0000_0030) begin errors++; $display("FAIL eret_exc_cause got %h exp %h", v, 32'h0000_0030); end
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_FF03);
    eret = 1'b0;
    rd(5'd12, v); checks++; if (v !== 32'h0000_FF01) begin errors++; $display("FAIL eret_mtc0_status got %h exp %h", v, 32'h0000_FF01); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL eret_int got %b exp 0", int_req); end
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_hw_int();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 5'b00001;
    #1;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL hw_int_early got %b exp 0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL hw_int_req got %b exp 1", int_req); end
    rd(5'd13, v); checks++; if (v !== 32'h0000_0430) begin errors++; $display("FAIL hw_int_cause got %h exp %h", v, 32'h0000_0430); end
    mtc0(5'd12, 32'h0000_0403);
    checks++; if (int_req !== 1'b0 || exl_out !== 1'b1) begin errors++; $display("FAIL hw_int_exl got int=%b exl=%b exp 0 1", int_req, exl_out); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); checks++; if (v !== 32'h0000_0730) begin errors++; $display("FAIL cause_wmask got %h exp %h", v, 32'h0000_0730); end
    mtc0(5'd12, 32'h0000_0101);
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL sw_int_req got %b exp 1", int_req); end
    mtc0(5'd13, 32'h0);
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL sw_int_clear got %b exp 0", int_req); end
    hw_int = 5'b00000;
    tick();
    rd(5'd13, v); checks++; if (v !== 32'h0000_0030) begin errors++; $display("FAIL hw_int_drop got %h exp %h", v, 32'h0000_0030); end
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_wrap_and_map();
    logic [31:0] v;
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hold got %h exp %h", v, 32'hFFFF_FFFF); end
    tick();
    rd(5'd9, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp %h", v, 32'h0); end
    mtc0(5'd15, 32'h0);
    mtc0(5'd3, 32'h5555_5555);
    mtc0(5'd8, 32'h0);
    rd(5'd15, v); checks++; if (v !== 32'h0001_8000) begin errors++; $display("FAIL prid got %h exp %h", v, 32'h0001_8000); end
    rd(5'd3, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reg3 got %h exp %h", v, 32'h0); end
    rd(5'd8, v);  checks++; if (v !== 32'h1234_5677) begin errors++; $display("FAIL badvaddr_ro got %h exp %h", v, 32'h1234_5677); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    rst_n = 1'b0;
    #1;
    rd(5'd9, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rmid_count got %h exp %h", v, 32'h0); end
    rd(5'd11, v); checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rmid_compare got %h exp %h", v, 32'hFFFF_FFFF); end
    checks++; if (epc_out !== 32'h0 || exl_out !== 1'b0) begin errors++; $display("FAIL rmid_outs got epc=%h exl=%b exp 0 0", epc_out, exl_out); end
    rst_n = 1'b1;
    tick();
    rd(5'd9, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rmid_tick1 got %h exp %h", v, 32'h0); end
    tick();
    rd(5'd9, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL rmid_tick2 got %h exp %h", v, 32'h1); end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
    eret = 1'b0; hw_int = '0;
    test_reset();
    test_timer();
    test_exception();
    test_eret();
    test_hw_int();
    test_wrap_and_map();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
